// File: rtl/stack_ptr14b.sv
// Hardware stack pointer with full/empty tracking, sticky overflow/underflow and a RUN/FAULT FSM.
// Optional occupancy watermark on max_depth is enabled by defining STACK_PTR_WATERMARK_EN.
module stack_ptr14b #(
   parameter logic [13:0] SP_TOP    = 14'h3FFF,
   parameter logic [13:0] SP_BOTTOM = 14'h3C00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        load,
   input  logic [13:0] load_val,
   input  logic        clear_err,
   output logic [13:0] sp,
   output logic        empty,
   output logic        full,
   output logic        overflow,
   output logic        underflow,
   output logic        fault,
   output logic [13:0] max_depth
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [13:0] r_sp;
   logic [13:0] w_spNext;
   logic        r_empty;
   logic        r_full;
   logic        r_overflow;
   logic        r_underflow;
   logic        w_overflowNext;
   logic        w_underflowNext;
   logic        w_pushBlocked;
   logic        w_popBlocked;

   // A loaded pointer may sit outside the legal window, so the 14-bit extremes also block push/pop to prevent wrap.
   assign w_pushBlocked = r_full  || (r_sp == 14'h0000);
   assign w_popBlocked  = r_empty || (r_sp == 14'h3FFF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext     = r_state;
      w_spNext        = r_sp;
      w_overflowNext  = r_overflow;
      w_underflowNext = r_underflow;
      if (clear_err) begin
         w_stateNext     = RUN;
         w_overflowNext  = 1'b0;
         w_underflowNext = 1'b0;
      end else if (r_state == RUN) begin
         if (load) begin
            w_spNext = load_val;
         end else if (push && pop) begin
            w_spNext = r_sp;
         end else if (push) begin
            if (w_pushBlocked) begin
               w_overflowNext = 1'b1;
               w_stateNext    = FAULT;
            end else begin
               w_spNext = r_sp - 14'd1;
            end
         end else if (pop) begin
            if (w_popBlocked) begin
               w_underflowNext = 1'b1;
               w_stateNext     = FAULT;
            end else begin
               w_spNext = r_sp + 14'd1;
            end
         end
      end
   end

   always_comb begin
      fault = (r_state == FAULT);
   end

   // empty/full are derived from the next pointer so they land in the same cycle as sp.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp        <= SP_TOP;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_sp        <= w_spNext;
         r_empty     <= (w_spNext == SP_TOP);
         r_full      <= (w_spNext == SP_BOTTOM);
         r_overflow  <= w_overflowNext;
         r_underflow <= w_underflowNext;
      end
   end

   assign sp        = r_sp;
   assign empty     = r_empty;
   assign full      = r_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

`ifdef STACK_PTR_WATERMARK_EN
   logic [13:0] r_maxDepth;
   logic [13:0] w_newDepth;

   // Every prior sp is already folded in, so tracking the next sp each cycle covers all updates.
   assign w_newDepth = (w_spNext > SP_TOP) ? 14'd0 : (SP_TOP - w_spNext);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_maxDepth <= 14'd0;
      end else if (w_newDepth > r_maxDepth) begin
         r_maxDepth <= w_newDepth;
      end
   end

   assign max_depth = r_maxDepth;
`else
   assign max_depth = 14'd0;
`endif

endmodule

// File: tb/tb_stack_ptr14b.sv
// Self-checking bench for stack_ptr14b: a directed vector table plus hand-written reset sequences.
// Expected max_depth follows STACK_PTR_WATERMARK_EN when it is defined for the build.
module tb_stack_ptr14b;

   logic        clk;
   logic        reset;
   logic        push;
   logic        pop;
   logic        load;
   logic [13:0] load_val;
   logic        clear_err;
   logic [13:0] sp;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;
   logic        fault;
   logic [13:0] max_depth;

   int checks   = 0;
   int failures = 0;

`ifdef STACK_PTR_WATERMARK_EN
   localparam bit WM = 1'b1;
`else
   localparam bit WM = 1'b0;
`endif

   typedef struct {
      logic        push;
      logic        pop;
      logic        load;
      logic [13:0] loadVal;
      logic        clr;
      logic [13:0] expSp;
      logic        expEmpty;
      logic        expFull;
      logic        expOvf;
      logic        expUnf;
      logic        expFault;
      logic [13:0] expMd;
   } vec_t;

   vec_t vecs[23];

   stack_ptr14b dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .load      (load),
      .load_val  (load_val),
      .clear_err (clear_err),
      .sp        (sp),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .fault     (fault),
      .max_depth (max_depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [13:0] eSp, input logic eEmpty,
                              input logic eFull, input logic eOvf, input logic eUnf,
                              input logic eFault, input logic [13:0] eMd);
      checkVal({tag, ".sp"}, sp, eSp);
      checkVal({tag, ".empty"}, {13'd0, empty}, {13'd0, eEmpty});
      checkVal({tag, ".full"}, {13'd0, full}, {13'd0, eFull});
      checkVal({tag, ".overflow"}, {13'd0, overflow}, {13'd0, eOvf});
      checkVal({tag, ".underflow"}, {13'd0, underflow}, {13'd0, eUnf});
      checkVal({tag, ".fault"}, {13'd0, fault}, {13'd0, eFault});
      checkVal({tag, ".max_depth"}, max_depth, WM ? eMd : 14'd0);
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
   task automatic applyStimulus(input logic iPush, input logic iPop, input logic iLoad,
                                input logic [13:0] iVal, input logic iClr);
      push      = iPush;
      pop       = iPop;
      load      = iLoad;
      load_val  = iVal;
      clear_err = iClr;
      @(posedge clk);
      #1;
      push      = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
      clear_err = 1'b0;
   endtask

   initial begin
      //                push pop load loadVal    clr   sp        e  f  ov un flt md
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3FFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3FFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3FFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0003};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3FFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0003};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3FFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0003};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 14'h3FF0, 1'b0, 14'h3FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 14'h3FFB, 1'b0, 14'h3FFB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 14'h3FFF, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h000F};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h000F};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 14'h0100, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h000F};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 14'h0200, 1'b1, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3FFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h000F};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 14'h3C01, 1'b0, 14'h3C01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h03FE};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h03FF};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h3C00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 14'h03FF};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3C00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 14'h03FF};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h03FF};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h3C01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h03FF};
      vecs[20] = '{1'b0, 1'b0, 1'b1, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h3FFF};
      vecs[21] = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h3FFF};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h3FFF};

      reset     = 1'b1;
      push      = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
      load_val  = 14'h0000;
      clear_err = 1'b0;
      #1;
      checkOutput("reset_async", 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_hold", 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].load, vecs[i].loadVal, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), vecs[i].expSp, vecs[i].expEmpty, vecs[i].expFull,
                     vecs[i].expOvf, vecs[i].expUnf, vecs[i].expFault, vecs[i].expMd);
      end

      // Reset lands between edges in the middle of a push burst; sp must return at once.
      applyStimulus(1'b0, 1'b0, 1'b1, 14'h3FFF, 1'b0);
      push = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      checkVal("burst.sp_before_reset", sp, 14'h3FFD);
      reset = 1'b1;
      #1;
      checkOutput("midcycle_reset", 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
      push = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_held_edge", 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 14'h0000, 1'b0);
      checkOutput("first_after_reset", 14'h3FFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stack_ptr14b.md
STACK_PTR14B -- requirements
Module: stack_ptr14b

Interface
REQ-001 SHALL have parameter SP_TOP, default 14'h3FFF: empty-stack pointer value and reset value of sp.
REQ-002 SHALL have parameter SP_BOTTOM, default 14'h3C00: lowest legal pointer value (stack full); SP_BOTTOM < SP_TOP.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  request to decrement sp by one.
REQ-006 SHALL have port pop  input  1  request to increment sp by one.
REQ-007 SHALL have port load  input  1  request to overwrite sp with load_val.
REQ-008 SHALL have port load_val  input  14  value for load.
REQ-009 SHALL have port clear_err  input  1  leave FAULT state and clear error flags.
REQ-010 SHALL have port sp  output  14  registered stack pointer.
REQ-011 SHALL have ports empty and full  output  1 each  registered, sp==SP_TOP and sp==SP_BOTTOM respectively.
REQ-012 SHALL have ports overflow and underflow  output  1 each  sticky error flags.
REQ-013 SHALL have port fault  output  1  high while the FSM is in FAULT.
REQ-014 SHALL have port max_depth  output  14  deepest occupancy reached (SP_TOP minus lowest sp).

Function
REQ-015 SHALL implement a two-state FSM, RUN and FAULT, entering RUN on reset.
REQ-016 SHALL, in RUN, give priority load > (push&pop) > push > pop, evaluated at each rising clk edge.
REQ-017 SHALL, on load, set sp to load_val the next cycle regardless of range, with no error.
REQ-018 SHALL, on push and pop in the same cycle, leave sp unchanged and raise no error.
REQ-019 SHALL, on push alone with full low, set sp to sp-1 (14-bit, one-cycle latency).
REQ-020 SHALL, on pop alone with empty low, set sp to sp+1 (14-bit, one-cycle latency).
REQ-021 SHALL, on push alone while full, hold sp, set overflow and enter FAULT.
REQ-022 SHALL, on pop alone while empty, hold sp, set underflow and enter FAULT.
REQ-023 SHALL, in FAULT, ignore push, pop and load and hold sp and all flags.
REQ-024 SHALL, on clear_err in any state, clear overflow and underflow and return to RUN next cycle; clear_err takes priority over push, pop and load in the same cycle, which are ignored.
REQ-025 SHALL update empty and full in the same cycle as sp, so they are always consistent with the registered sp.
REQ-026 SHALL never wrap sp through 14'h0000 or 14'h3FFF via push or pop; only load may place sp outside [SP_BOTTOM, SP_TOP].

Reset
REQ-027 SHALL, on reset assertion, immediately set sp=SP_TOP, empty=1, full=0, overflow=0, underflow=0, fault=0, max_depth=0 and the state to RUN.
REQ-028 SHALL abandon any in-flight operation when reset asserts mid-cycle; the first operation is sampled on the first rising clk edge after deassertion.

Configuration
REQ-029 SHALL, with macro STACK_PTR_WATERMARK_EN defined, register max_depth = max(max_depth, SP_TOP - new sp) on every sp update; a load is included and values above SP_TOP count as depth 0.
REQ-030 SHALL, without STACK_PTR_WATERMARK_EN, drive max_depth constant 0 and contain no watermark register.

Verification
REQ-031 SHALL cover: reset, then three push cycles -> sp=14'h3FFC, empty=0, max_depth=3 (watermark build).
REQ-032 SHALL cover: from reset, pop -> sp stays 14'h3FFF, underflow=1, fault=1; further push ignored; clear_err -> fault=0 next cycle; then push -> sp=14'h3FFE.
REQ-033 SHALL cover: load 14'h3C01, push -> sp=14'h3C00, full=1; push -> overflow=1, sp stays 14'h3C00.
REQ-034 SHALL cover: push&pop together at sp=14'h3FF0 -> sp stays 14'h3FF0; load with push&pop -> sp=load_val.
REQ-035 SHALL cover: reset asserted between clk edges during a push burst -> sp=14'h3FFF immediately, before the next edge.
